// File: rtl/game_pkg.sv
// Shared types and constants for the frame-rate game controller.
// Holds the FSM encoding, coordinate widths and the BCD magnitude compare.
package game_pkg;

    localparam int COORD_W = 11;
    localparam int SIZE_W  = 10;
    localparam int SUM_W   = 12;
    localparam int BCD_W   = 4;
    localparam int DIV_W   = 6;
    localparam int BCD_MAX_DIGITS = 16;

    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DEAD    = 2'd2,
        ST_RESTART = 2'd3
    } game_state_e;

    // Most significant differing digit decides; callers zero-extend to 64 bits.
    function automatic logic bcd_gt(input logic [BCD_W*BCD_MAX_DIGITS-1:0] a,
                                    input logic [BCD_W*BCD_MAX_DIGITS-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
                gt      = (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/game_controller_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear, ripple carry and
// saturation at all nines.
module bcd_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [BCD_W*DIGITS-1:0]   q,
    output logic                      sat
);

    logic [BCD_W*DIGITS-1:0] q_q;
    logic [BCD_W*DIGITS-1:0] q_d;
    logic                    sat_w;

    always_comb begin
        sat_w = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q_q[i*BCD_W +: BCD_W] != BCD_NINE) begin
                sat_w = 1'b0;
            end
        end
    end

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        logic carry;
        q_d   = q_q;
        carry = inc & ~sat_w;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (q_q[i*BCD_W +: BCD_W] == BCD_NINE) begin
                    q_d[i*BCD_W +: BCD_W] = '0;
                end else begin
                    q_d[i*BCD_W +: BCD_W] = q_q[i*BCD_W +: BCD_W] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
        if (clr) begin
            q_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign sat = sat_w;

endmodule

// File: rtl/game_controller.sv
// Frame-rate game flow: box collision, IDLE/RUN/DEAD/RESTART sequencing,
// button gating, BCD score with saturation and a best-score register.
module game_controller
    import game_pkg::*;
#(
    parameter int SCORE_DIGITS = 5,
    parameter int SCORE_DIV    = 6
) (
    input  logic                         FrameClk,
    input  logic                         rst,
    input  logic                         jumpBtn,
    input  logic                         duckBtn,
    input  logic [COORD_W-1:0]           Dino_X,
    input  logic [COORD_W-1:0]           Dino_Y,
    input  logic [SIZE_W-1:0]            DinoWidth,
    input  logic [SIZE_W-1:0]            DinoHeight,
    input  logic [COORD_W-1:0]           obsX,
    input  logic [COORD_W-1:0]           obsY,
    input  logic [SIZE_W-1:0]            obsW,
    input  logic [SIZE_W-1:0]            obsH,
    input  logic                         obsValid,
    output logic                         jump,
    output logic                         duck,
    output logic                         isDead,
    output logic                         running,
    output logic                         restart,
    output logic [BCD_W*SCORE_DIGITS-1:0] score,
    output logic [BCD_W*SCORE_DIGITS-1:0] highScore,
    output logic                         scoreTick
);

    localparam int                SW       = BCD_W * SCORE_DIGITS;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCORE_DIV - 1);

    game_state_e       state_q;
    logic              jump_prev_q;
    logic [DIV_W-1:0]  div_q;
    logic [SW-1:0]     high_q;
    logic              jump_q;
    logic              duck_q;
    logic              dead_q;
    logic              run_q;
    logic              restart_q;
    logic              tick_q;

    logic [SUM_W-1:0]  dino_right;
    logic [SUM_W-1:0]  dino_bottom;
    logic [SUM_W-1:0]  obs_right;
    logic [SUM_W-1:0]  obs_bottom;
    logic              nonempty;
    logic              overlap;
    logic              jump_rise;
    logic              div_wrap;
    logic              score_clr;
    logic              score_inc;
    logic [SW-1:0]     score_q;
    logic              score_sat;

    // Half-open boxes: an empty box would still satisfy the strict
    // inequalities for some positions, so zero sizes are excluded explicitly.
    assign dino_right  = SUM_W'(Dino_X) + SUM_W'(DinoWidth);
    assign dino_bottom = SUM_W'(Dino_Y) + SUM_W'(DinoHeight);
    assign obs_right   = SUM_W'(obsX)   + SUM_W'(obsW);
    assign obs_bottom  = SUM_W'(obsY)   + SUM_W'(obsH);
    assign nonempty    = (|DinoWidth) & (|DinoHeight) & (|obsW) & (|obsH);

    assign overlap = obsValid & nonempty
                   & (SUM_W'(Dino_X) < obs_right)
                   & (SUM_W'(obsX)   < dino_right)
                   & (SUM_W'(Dino_Y) < obs_bottom)
                   & (SUM_W'(obsY)   < dino_bottom);

    assign jump_rise = jumpBtn & ~jump_prev_q;
    assign div_wrap  = (div_q == DIV_LAST);

    always_comb begin
        score_clr = 1'b0;
        score_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DEAD: score_clr = jump_rise;
            ST_RESTART:       score_clr = 1'b1;
            ST_RUN:           score_inc = ~overlap & div_wrap;
            default:          score_clr = 1'b0;
        endcase
    end

    bcd_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk (FrameClk),
        .rst (rst),
        .clr (score_clr),
        .inc (score_inc),
        .q   (score_q),
        .sat (score_sat)
    );

    always_ff @(posedge FrameClk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            jump_prev_q <= 1'b0;
            div_q       <= '0;
            high_q      <= '0;
            jump_q      <= 1'b0;
            duck_q      <= 1'b0;
            dead_q      <= 1'b0;
            run_q       <= 1'b0;
            restart_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            jump_prev_q <= jumpBtn;
            jump_q      <= (state_q == ST_RUN) & jumpBtn;
            duck_q      <= (state_q == ST_RUN) & duckBtn & ~jumpBtn;
            restart_q   <= 1'b0;
            tick_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (jump_rise) begin
                        state_q   <= ST_RESTART;
                        restart_q <= 1'b1;
                    end
                end
                ST_RESTART: begin
                    state_q <= ST_RUN;
                    run_q   <= 1'b1;
                    dead_q  <= 1'b0;
                    div_q   <= '0;
                end
                ST_RUN: begin
                    // A collision pre-empts any score increment due on this edge.
                    if (overlap) begin
                        state_q <= ST_DEAD;
                        run_q   <= 1'b0;
                        dead_q  <= 1'b1;
                        if (bcd_gt(64'(score_q), 64'(high_q))) begin
                            high_q <= score_q;
                        end
                    end else begin
                        div_q  <= div_wrap ? '0 : div_q + 1'b1;
                        tick_q <= div_wrap & ~score_sat;
                    end
                end
                ST_DEAD: begin
                    if (jump_rise) begin
                        state_q   <= ST_RESTART;
                        restart_q <= 1'b1;
                        dead_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign jump      = jump_q;
    assign duck      = duck_q;
    assign isDead    = dead_q;
    assign running   = run_q;
    assign restart   = restart_q;
    assign score     = score_q;
    assign highScore = high_q;
    assign scoreTick = tick_q;

endmodule

// File: doc/game_controller.md
# game_controller

Frame-rate game-state controller, directly downstream of TRexDelegate. Each FrameClk it compares the dino bounding box (Dino_X/Dino_Y/DinoWidth/DinoHeight) with the active obstacle's box and declares death on overlap. It runs the IDLE/RUN/DEAD/RESTART game flow and gates the raw buttons into the jump/duck/isDead controls used by the dino and obstacle logic. It also keeps a saturating BCD score and a high score for the display stage.

## Interface
Parameters:
- SCORE_DIGITS, 5: number of BCD digits in score and highScore.
- SCORE_DIV, 6: RUN frames per score increment; legal range 1..63.

Ports (one clock; reset is synchronous and active-high):
- FrameClk  in  1  frame-rate clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- jumpBtn  in  1  raw jump button level, already synchronised.
- duckBtn  in  1  raw duck button level.
- Dino_X, Dino_Y  in  11 each  dino box top-left corner.
- DinoWidth, DinoHeight  in  10 each  dino box size.
- obsX, obsY  in  11 each  obstacle box top-left corner.
- obsW, obsH  in  10 each  obstacle box size.
- obsValid  in  1  obstacle box is meaningful this frame.
- jump  out  1  gated jump request to the dino.
- duck  out  1  gated duck request.
- isDead  out  1  high in DEAD.
- running  out  1  high in RUN.
- restart  out  1  one-frame pulse that resets the obstacle/ground scrollers.
- score  out  4*SCORE_DIGITS  current score, BCD, digit 0 in LSBs.
- highScore  out  4*SCORE_DIGITS  best score since reset, BCD.
- scoreTick  out  1  one-frame pulse whenever score increments.

## Operation
- A box spans [X, X+W) x [Y, Y+H). Y grows downward.
- Overlap requires all of the following: obsValid; Dino_X < obsX+obsW; obsX < Dino_X+DinoWidth; Dino_Y < obsY+obsH; obsY < Dino_Y+DinoHeight.
- Sums are formed at 12 bits, so no wrap. A zero width or height never overlaps.
- The overlap signal is combinational from current inputs and is consumed only by the FSM.
- jumpRise = jumpBtn & ~jumpPrev, where jumpPrev is a registered copy of jumpBtn.
- IDLE: score holds 0. On jumpRise, go to RESTART.
- RESTART: stays exactly one frame; restart=1; score cleared to 0; divider cleared to 0. Then go to RUN.
- RUN:
  - If overlap, go to DEAD. On this same edge, highScore <= score if score > highScore (BCD compare, MSD first).
  - Otherwise the divider increments. When the divider reaches SCORE_DIV-1, it wraps to 0, score increments, and scoreTick pulses.
- DEAD: score and highScore hold. Leave only on a jumpRise that occurs at least one full frame after entering DEAD; then go to RESTART.
- Gating, all registered:
  - jump = RUN & jumpBtn.
  - duck = RUN & duckBtn & ~jumpBtn; jump has priority.
  - Outside RUN, jump=0 and duck=0.
- Score saturates at all 9s: no increment and no scoreTick once saturated. The divider keeps running.

## Timing
- Reset: state=IDLE; jumpPrev=0; divider=0; score=0; highScore=0; jump=duck=isDead=running=restart=scoreTick=0.
- rst has priority over every other event on the same edge.
- Every output is a register and changes one edge after the qualifying input edge.
- Overlap sampled at edge t: isDead=1 and running=0 from edge t+1.
- Collision and score increment due on the same edge: collision wins, so no increment and no scoreTick.
- jumpRise in IDLE at edge t: restart=1 for the frame t+1..t+2; running=1 from t+2.
  - The first jump output can go high at edge t+3 at the earliest, if jumpBtn is still high.
- Holding jumpBtn through death does not restart, because a new rising edge is required.
- rst asserted in any state, including mid-RESTART: IDLE on the next edge and no restart pulse. highScore is lost.
- DEAD-entry guard: a jumpRise on the DEAD-entry edge itself is ignored.

## Structure
- Shared package game_pkg:
  - state encoding, 2 bits: IDLE=0, RUN=1, DEAD=2, RESTART=3.
  - COORD_W=11.
  - SIZE_W=10.
  - BCD digit width 4.
- Sub-module bcd_counter #(DIGITS):
  - inputs clr and inc; outputs q and sat.
  - ripple-carry BCD increment with saturation.
  - one instance for score.
- highScore and the BCD compare live in the top level.

## Test plan
- Reset then idle: hold rst 2 frames, release, no buttons for 10 frames. All outputs stay 0 and score=0.
- Start and score, SCORE_DIV=6, obsValid=0:
  - jumpBtn rises at frame 0: restart pulses at frame 1, running from frame 2.
  - After 60 RUN frames: score=0x00010, with 10 scoreTick pulses.
- Collision boundaries:
  - Dino box (50,100,40,43) with obstacle at obsX=90 (edge-touching, not overlapping): no death.
  - obsX=89: isDead=1 the next frame.
  - Same overlap with obsValid=0: no death.
- Death and restart:
  - Die with score=0x00023: highScore=0x00023.
  - jumpBtn held through death: stays DEAD.
  - Release, then press: RESTART, score=0; highScore stays 0x00023.
  - Die again at 0x00007: highScore unchanged.
- Gating priority in RUN:
  - jumpBtn=duckBtn=1: jump=1, duck=0.
  - duckBtn only: duck=1.
  - Same stimulus in DEAD: both 0.
- Saturation, SCORE_DIGITS=2: run until score=0x99. No further scoreTick; collision still asserts isDead.
